// File: rtl/obtc_pkg.sv
// rtl/obtc_pkg.sv - shared constants and types for the heavyhash reduce datapath
package obtc_pkg;
  localparam int HASH_W   = 256;
  localparam int NIB_W    = 4;
  localparam int PE_OUT_W = 14;
  localparam int ROWS     = 64;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUT
  } state_e;

  // One product nibble per matrix row; nib[r] is row r.
  typedef logic [ROWS-1:0][NIB_W-1:0] nib_arr_t;
endpackage

// File: rtl/pe_nibble_trunc.sv
// rtl/pe_nibble_trunc.sv - combinational truncation of PE sums to product nibbles
module pe_nibble_trunc
  import obtc_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int SHIFT  = 10
) (
  input  logic [NUM_PE*PE_OUT_W-1:0] sums,
  output logic [NUM_PE*NIB_W-1:0]    nibs
);

  // Bits of the shifted sum above the nibble are dropped, never saturated.
  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    assign nibs[k*NIB_W +: NIB_W] = NIB_W'(sums[k*PE_OUT_W +: PE_OUT_W] >> SHIFT);
  end

endmodule

// File: rtl/heavyhash_reduce.sv
// rtl/heavyhash_reduce.sv - collects PE row sums, packs nibbles and XORs with the SHA3 hash
module heavyhash_reduce
  import obtc_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int SHIFT  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [HASH_W-1:0]          hash_in,
  input  logic                       hash_valid,
  output logic                       hash_ready,
  input  logic [NUM_PE*PE_OUT_W-1:0] pe_out,
  input  logic                       pe_valid,
  output logic                       pe_ready,
  output logic [HASH_W-1:0]          res_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       drop_err
);

  localparam int PASSES = ROWS / NUM_PE;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int ROW_W  = $clog2(ROWS);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  state_e                   state_q, state_d;
  logic [PASS_W-1:0]        pass_q, pass_d;
  nib_arr_t                 nib_q, nib_d;
  logic [HASH_W-1:0]        hash_q, hash_d;
  logic [HASH_W-1:0]        res_q, res_d;
  logic                     res_valid_q, res_valid_d;
  logic                     pe_ready_q, pe_ready_d;
  logic                     hash_ready_q, hash_ready_d;
  logic                     busy_q, busy_d;
  logic                     drop_err_q, drop_err_d;
  logic [ROW_W-1:0]         row;
  logic [NUM_PE*NIB_W-1:0]  pass_nibs;

  pe_nibble_trunc #(
    .NUM_PE(NUM_PE),
    .SHIFT (SHIFT)
  ) u_trunc (
    .sums(pe_out),
    .nibs(pass_nibs)
  );

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    nib_d      = nib_q;
    hash_d     = hash_q;
    res_d      = res_q;
    drop_err_d = drop_err_q;
    row        = '0;

    case (state_q)
      IDLE: begin
        if (hash_valid && hash_ready_q) begin
          hash_d  = hash_in;
          pass_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (pe_valid && pe_ready_q) begin
          for (int k = 0; k < NUM_PE; k++) begin
            row        = ROW_W'(int'(pass_q) * NUM_PE + k);
            nib_d[row] = pass_nibs[k*NIB_W +: NIB_W];
          end
          // The counter parks on the last pass instead of wrapping.
          if (pass_q == LAST_PASS) begin
            state_d = OUT;
          end else begin
            pass_d = pass_q + PASS_W'(1);
          end
        end
      end
      OUT: begin
        if (res_valid_q && res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pe_valid && (state_q != COLLECT)) begin
      drop_err_d = 1'b1;
    end

    // Result is frozen into res_q once, so it holds steady under backpressure.
    if ((state_q == COLLECT) && (state_d == OUT)) begin
      for (int i = 0; i < HASH_W / 8; i++) begin
        res_d[8*i +: 8] = {nib_d[2*i], nib_d[2*i+1]} ^ hash_q[8*i +: 8];
      end
    end

    hash_ready_d = (state_d == IDLE);
    pe_ready_d   = (state_d == COLLECT);
    res_valid_d  = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pass_q       <= '0;
      nib_q        <= '0;
      hash_q       <= '0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      pe_ready_q   <= 1'b0;
      hash_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      nib_q        <= nib_d;
      hash_q       <= hash_d;
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      pe_ready_q   <= pe_ready_d;
      hash_ready_q <= hash_ready_d;
      busy_q       <= busy_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign hash_ready = hash_ready_q;
  assign pe_ready   = pe_ready_q;
  assign res_out    = res_q;
  assign res_valid  = res_valid_q;
  assign busy       = busy_q;
  assign drop_err   = drop_err_q;

endmodule
